vjtag_dsa_ctrl: RTL and testbench

- JTAG-side command/data engine directly downstream of the vjtag_dsa virtual JTAG instance; consumes its tdi, ir_in and virtual_state_* outputs and drives its tdo and ir_out.
- Runs entirely on tck. Decodes the 2-bit IR into address load, streaming byte write, streaming byte read, and control/status access.
- Converts each access into a simple synchronous memory port (image buffer of the bilinear interpolation DSA) and start/done handshakes.

---
 rtl/vjtag_dsa_ctrl_if.sv | 38 +++
 rtl/vjtag_dsa_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_vjtag_dsa_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vjtag_dsa_ctrl_if.sv
// ---------------------------------------------------------------------------
// vjtag_dsa_ctrl_if
// Bus between the JTAG command engine and the bilinear-interpolation DSA:
// a simple synchronous image-buffer memory port plus the start/done
// handshake.
//   mem_addr     : memory address pointer (engine -> memory)
//   mem_wdata    : write data (engine -> memory)
//   mem_we       : one-cycle write strobe (engine -> memory)
//   mem_rdata    : read data, valid one tck after mem_addr changes
//   dsa_busy     : DSA running (DSA -> engine)
//   dsa_done     : DSA finished, sticky inside the DSA (DSA -> engine)
//   dsa_start    : one-cycle start pulse (engine -> DSA)
//   dsa_done_clr : one-cycle clear pulse for dsa_done (engine -> DSA)
// master = command engine side, slave = memory/DSA side.
// ---------------------------------------------------------------------------
interface vjtag_dsa_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 18
) ();
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              dsa_busy;
   logic              dsa_done;
   logic              dsa_start;
   logic              dsa_done_clr;

   modport master (
      output mem_addr, mem_wdata, mem_we, dsa_start, dsa_done_clr,
      input  mem_rdata, dsa_busy, dsa_done
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_we, dsa_start, dsa_done_clr,
      output mem_rdata, dsa_busy, dsa_done
   );
endinterface

// File: rtl/vjtag_dsa_ctrl.sv
// ---------------------------------------------------------------------------
// vjtag_dsa_ctrl
// JTAG-side command/data engine sitting behind the vjtag_dsa virtual JTAG
// instance. Runs entirely on tck. The 2-bit virtual IR selects:
//   00 ADDR  : ADDR_W-bit address register (capture current, update loads)
//   01 WRITE : gapless byte stream written to memory, address auto-increments
//   10 READ  : gapless byte stream read from memory with prefetch
//   11 CTRL  : DSA status capture / start and done-clear pulses
// Ports:
//   tck, rst            : JTAG clock, asynchronous active-high reset
//   tdi / tdo           : serial data in/out (LSB first)
//   ir_in / ir_out      : current instruction / {dsa_done, dsa_busy}
//   virtual_state_cdr/sdr/udr : Capture-DR, Shift-DR, Update-DR
//   bus                 : memory port and DSA handshake (master modport)
// ---------------------------------------------------------------------------
module vjtag_dsa_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 18
) (
   input  logic                  tck,
   input  logic                  rst,
   input  logic                  tdi,
   output logic                  tdo,
   input  logic [1:0]            ir_in,
   output logic [1:0]            ir_out,
   input  logic                  virtual_state_cdr,
   input  logic                  virtual_state_sdr,
   input  logic                  virtual_state_udr,
   vjtag_dsa_ctrl_if.master      bus
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {
      IR_ADDR  = 2'b00,
      IR_WRITE = 2'b01,
      IR_READ  = 2'b10,
      IR_CTRL  = 2'b11
   } ir_e;

   logic [ADDR_W-1:0] sr_addr_q,   sr_addr_d;
   logic [DATA_W-1:0] data_sr_q,   data_sr_d;
   logic [DATA_W-1:0] sr_ctl_q,    sr_ctl_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_we_q,    mem_we_d;
   logic              dsa_start_q, dsa_start_d;
   logic              done_clr_q,  done_clr_d;

   logic              cnt_last;
   logic [CNT_W-1:0]  cnt_next;
   logic [ADDR_W-1:0] addr_base;
   logic [DATA_W-1:0] data_shifted;
   ir_e               ir;

   assign ir           = ir_e'(ir_in);
   assign cnt_last     = (cnt_q == CNT_W'(DATA_W - 1));
   assign cnt_next     = cnt_last ? '0 : cnt_q + 1'b1;
   assign data_shifted = {tdi, data_sr_q[DATA_W-1:1]};

   // A strobed write leaves mem_we high for exactly one tck; the address
   // step that follows it must happen whatever the IR or TAP state is now,
   // so every other address update is built on top of this base.
   assign addr_base = mem_we_q ? mem_addr_q + 1'b1 : mem_addr_q;

   // Next-state decode for all four data registers. The TAP states are
   // mutually exclusive, so each IR branch picks at most one action and
   // all shift registers hold otherwise.
   always_comb begin
      sr_addr_d   = sr_addr_q;
      data_sr_d   = data_sr_q;
      sr_ctl_d    = sr_ctl_q;
      cnt_d       = cnt_q;
      mem_addr_d  = addr_base;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      dsa_start_d = 1'b0;
      done_clr_d  = 1'b0;

      unique case (ir)
         IR_ADDR: begin
            if (virtual_state_cdr) begin
               sr_addr_d = mem_addr_q;
            end else if (virtual_state_sdr) begin
               sr_addr_d = {tdi, sr_addr_q[ADDR_W-1:1]};
            end else if (virtual_state_udr) begin
               mem_addr_d = sr_addr_q;
            end
         end

         // Partial bytes left at Update-DR are simply never strobed; the
         // counter restarts on the next capture.
         IR_WRITE: begin
            if (virtual_state_cdr) begin
               cnt_d = '0;
            end else if (virtual_state_sdr) begin
               data_sr_d = data_shifted;
               cnt_d     = cnt_next;
               if (cnt_last) begin
                  mem_wdata_d = data_shifted;
                  mem_we_d    = 1'b1;
               end
            end
         end

         // The byte being shifted out was prefetched, and the address moves
         // on to the following byte at the same time, so mem_rdata has
         // DATA_W-1 cycles to settle before the next reload.
         IR_READ: begin
            if (virtual_state_cdr) begin
               data_sr_d  = bus.mem_rdata;
               cnt_d      = '0;
               mem_addr_d = addr_base + 1'b1;
            end else if (virtual_state_sdr) begin
               cnt_d = cnt_next;
               if (cnt_last) begin
                  data_sr_d  = bus.mem_rdata;
                  mem_addr_d = addr_base + 1'b1;
               end else begin
                  data_sr_d = data_shifted;
               end
            end
         end

         // A start request while the DSA is busy is dropped, not queued.
         IR_CTRL: begin
            if (virtual_state_cdr) begin
               sr_ctl_d      = '0;
               sr_ctl_d[1:0] = {bus.dsa_done, bus.dsa_busy};
            end else if (virtual_state_sdr) begin
               sr_ctl_d = {tdi, sr_ctl_q[DATA_W-1:1]};
            end else if (virtual_state_udr) begin
               dsa_start_d = sr_ctl_q[0] & ~bus.dsa_busy;
               done_clr_d  = sr_ctl_q[1];
            end
         end

         default: ;
      endcase
   end

   // State registers; reset aborts any shift or pending write at once.
   always_ff @(posedge tck or posedge rst) begin
      if (rst) begin
         sr_addr_q   <= '0;
         data_sr_q   <= '0;
         sr_ctl_q    <= '0;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         dsa_start_q <= 1'b0;
         done_clr_q  <= 1'b0;
      end else begin
         sr_addr_q   <= sr_addr_d;
         data_sr_q   <= data_sr_d;
         sr_ctl_q    <= sr_ctl_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         dsa_start_q <= dsa_start_d;
         done_clr_q  <= done_clr_d;
      end
   end

   // tdo follows bit 0 of whichever register the current IR selects.
   always_comb begin
      tdo = 1'b0;
      unique case (ir)
         IR_ADDR:  tdo = sr_addr_q[0];
         IR_WRITE: tdo = data_sr_q[0];
         IR_READ:  tdo = data_sr_q[0];
         IR_CTRL:  tdo = sr_ctl_q[0];
         default:  tdo = 1'b0;
      endcase
   end

   assign ir_out           = {bus.dsa_done, bus.dsa_busy};
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.mem_we       = mem_we_q;
   assign bus.dsa_start    = dsa_start_q;
   assign bus.dsa_done_clr = done_clr_q;

endmodule

// File: tb/tb_vjtag_dsa_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vjtag_dsa_ctrl
// Directed bench for the JTAG command engine. A behavioural image buffer
// answers the memory port; expected writes and read bytes are queued when
// the stimulus is issued and popped when the engine produces them.
// ---------------------------------------------------------------------------
module tb_vjtag_dsa_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 18;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   logic        tck = 1'b0;
   logic        rst;
   logic        tdi;
   logic        tdo;
   logic [1:0]  ir_in;
   logic [1:0]  ir_out;
   logic        cdr, sdr, udr;

   int          total = 0;
   int          bad   = 0;

   wr_t               wr_q[$];
   wr_t               mon_e;
   logic [DATA_W-1:0] rd_q[$];
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   vjtag_dsa_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   vjtag_dsa_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .tck               (tck),
      .rst               (rst),
      .tdi               (tdi),
      .tdo               (tdo),
      .ir_in             (ir_in),
      .ir_out            (ir_out),
      .virtual_state_cdr (cdr),
      .virtual_state_sdr (sdr),
      .virtual_state_udr (udr),
      .bus               (bus.master)
   );

   always #5 tck = ~tck;

   // Synchronous image buffer: read data registered one tck after address.
   always @(posedge tck) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Every strobed write must match the head of the expected-write queue.
   always @(negedge tck) begin
      if (!rst && bus.mem_we) begin
         checkOutput("write_expected", 32'(wr_q.size() != 0), 32'd1);
         if (wr_q.size() != 0) begin
            mon_e = wr_q.pop_front();
            checkOutput("write_addr", 32'(bus.mem_addr), 32'(mon_e.a));
            checkOutput("write_data", 32'(bus.mem_wdata), 32'(mon_e.d));
         end
      end
   end

   // One tck of TAP activity: inputs change on the falling edge, tdo is
   // sampled just after, registered outputs are checked 1 ns past the rise.
   task automatic applyStimulus(input logic [1:0] ir, input logic c,
                                input logic s, input logic u, input logic d,
                                output logic b);
      @(negedge tck);
      ir_in = ir; cdr = c; sdr = s; udr = u; tdi = d;
      #1 b = tdo;
      @(posedge tck);
      #1;
   endtask

   task automatic idle(input int n);
      logic b;
      for (int i = 0; i < n; i++) applyStimulus(ir_in, 1'b0, 1'b0, 1'b0, 1'b0, b);
   endtask

   task automatic scanDr(input logic [1:0] ir, input int n,
                         input logic [31:0] din, output logic [31:0] dout);
      logic b;
      dout = '0;
      applyStimulus(ir, 1'b1, 1'b0, 1'b0, 1'b0, b);
      for (int i = 0; i < n; i++) begin
         applyStimulus(ir, 1'b0, 1'b1, 1'b0, din[i], b);
         dout[i] = b;
      end
   endtask

   task automatic updateDr(input logic [1:0] ir);
      logic b;
      applyStimulus(ir, 1'b0, 1'b0, 1'b1, 1'b0, b);
   endtask

   task automatic setAddr(input logic [31:0] a, output logic [31:0] old);
      scanDr(2'b00, ADDR_W, a, old);
      updateDr(2'b00);
      idle(2);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] dout;
      logic [31:0] old;

      rst = 1'b1; ir_in = 2'b00; cdr = 0; sdr = 0; udr = 0; tdi = 0;
      bus.dsa_busy = 1'b0; bus.dsa_done = 1'b0;
      #22;
      checkOutput("rst_mem_addr",  32'(bus.mem_addr), 32'h0);
      checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
      checkOutput("rst_mem_we",    32'(bus.mem_we), 32'h0);
      checkOutput("rst_start",     32'(bus.dsa_start), 32'h0);
      checkOutput("rst_done_clr",  32'(bus.dsa_done_clr), 32'h0);
      checkOutput("rst_tdo",       32'(tdo), 32'h0);
      @(negedge tck); rst = 1'b0;
      idle(2);

      $display("[TB] reset during write");
      setAddr(32'h55, old);
      checkOutput("first_capture", old, 32'h0);
      scanDr(2'b01, 8, 32'hFF, dout);
      checkOutput("we_before_rst", 32'(bus.mem_we), 32'h1);
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_mid_we",   32'(bus.mem_we), 32'h0);
      checkOutput("rst_mid_addr", 32'(bus.mem_addr), 32'h0);
      checkOutput("rst_mid_tdo",  32'(tdo), 32'h0);
      @(negedge tck); rst = 1'b0;
      idle(3);
      checkOutput("post_rst_addr", 32'(bus.mem_addr), 32'h0);
      checkOutput("post_rst_mem55", 32'(mem[18'h55]), 32'h0);

      $display("[TB] address load");
      setAddr(32'h00010, old);
      checkOutput("addr_loaded", 32'(bus.mem_addr), 32'h10);
      scanDr(2'b00, ADDR_W, 32'h00010, dout);
      checkOutput("addr_capture", dout, 32'h10);
      updateDr(2'b00);
      idle(1);

      $display("[TB] write stream");
      wr_q.push_back('{a: 18'h10, d: 8'hA5});
      wr_q.push_back('{a: 18'h11, d: 8'h3C});
      scanDr(2'b01, 19, {13'h0, 3'b101, 8'h3C, 8'hA5}, dout);
      updateDr(2'b01);
      idle(2);
      checkOutput("write_final_addr", 32'(bus.mem_addr), 32'h12);
      checkOutput("write_all_seen", 32'(wr_q.size()), 32'h0);

      $display("[TB] read stream");
      setAddr(32'h10, old);
      rd_q.push_back(8'hA5);
      rd_q.push_back(8'h3C);
      scanDr(2'b10, 16, 32'h0, dout);
      checkOutput("read_byte0", 32'(dout[7:0]), 32'(rd_q.pop_front()));
      checkOutput("read_byte1", 32'(dout[15:8]), 32'(rd_q.pop_front()));
      updateDr(2'b10);
      checkOutput("read_final_addr", 32'(bus.mem_addr), 32'h13);

      $display("[TB] address wrap");
      setAddr(32'h3FFFF, old);
      wr_q.push_back('{a: 18'h3FFFF, d: 8'h5A});
      scanDr(2'b01, 8, 32'h5A, dout);
      updateDr(2'b01);
      idle(1);
      checkOutput("wrap_addr", 32'(bus.mem_addr), 32'h0);
      checkOutput("wrap_all_seen", 32'(wr_q.size()), 32'h0);

      $display("[TB] control");
      bus.dsa_busy = 1'b0; bus.dsa_done = 1'b0;
      scanDr(2'b11, 8, 32'h01, dout);
      checkOutput("ctl_status_idle", dout, 32'h00);
      updateDr(2'b11);
      checkOutput("start_pulse", 32'(bus.dsa_start), 32'h1);
      checkOutput("start_no_clr", 32'(bus.dsa_done_clr), 32'h0);
      idle(1);
      checkOutput("start_low", 32'(bus.dsa_start), 32'h0);

      bus.dsa_busy = 1'b1;
      scanDr(2'b11, 8, 32'h01, dout);
      checkOutput("ctl_status_busy", dout, 32'h01);
      updateDr(2'b11);
      checkOutput("start_dropped", 32'(bus.dsa_start), 32'h0);

      bus.dsa_busy = 1'b0; bus.dsa_done = 1'b1;
      idle(1);
      checkOutput("ir_out_done", 32'(ir_out), 32'h2);
      scanDr(2'b11, 8, 32'h00, dout);
      checkOutput("ctl_status_done", dout, 32'h02);
      updateDr(2'b11);
      checkOutput("no_start_on_zero", 32'(bus.dsa_start), 32'h0);

      scanDr(2'b11, 8, 32'h02, dout);
      updateDr(2'b11);
      checkOutput("clr_pulse", 32'(bus.dsa_done_clr), 32'h1);
      checkOutput("clr_no_start", 32'(bus.dsa_start), 32'h0);
      idle(1);
      checkOutput("clr_low", 32'(bus.dsa_done_clr), 32'h0);

      idle(2);
      checkOutput("no_stray_writes", 32'(wr_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
